fifo_sync_flags: RTL and testbench
==================================

Name: fifo_sync_flags

Overview:
Parametrised single-clock FIFO, the next generation of the team's basic FIFO. Adds:
- selectable first-word-fall-through (show-ahead) or registered read mode;
- programmable almost-full and almost-empty thresholds;
- an occupancy count output;
- overflow and underflow error pulses;
- a synchronous flush.

It sits between testbench-driven producers and consumers and in datapath elastic buffers. It replaces the plain FIFO wherever flow-control margin or error visibility is needed.

Parameters:
- DATA_WIDTH, 8, data word width in bits.
- ADDR_WIDTH, 4, pointer width. DEPTH = 2**ADDR_WIDTH entries.
- SHOW_AHEAD, 0. 1 = FWFT (head word visible on data_out while !empty). 0 = registered read.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH. Legal range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous flush.
- data_in  in  DATA_WIDTH  write data.
- wr  in  1  write request.
- rd  in  1  read request.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: wr_ptr = rd_ptr = 0, count = 0, data_out = 0, overflow = underflow = 0. Hence empty = 1, full = 0, almost_empty = 1, almost_full = 0. Storage array is not reset.
- Accept rules, evaluated on the current-cycle state:
  - rd_ok = rd && !empty.
  - wr_ok = wr && (!full || rd).
  - When full, a simultaneous read frees a slot, so write and read are both accepted.
  - When empty, a simultaneous read is rejected and the write is accepted. Data is never bypassed in the same cycle.
- Pointers:
  - wr_ok: store data_in at wr_ptr, then wr_ptr+1.
  - rd_ok: rd_ptr+1.
  - Both pointers wrap modulo DEPTH naturally.
- count: count_next = count + wr_ok - rd_ok. It is held in ADDR_WIDTH+1 bits and never leaves 0..DEPTH. All flags decode combinationally from the registered count.
- Read data, SHOW_AHEAD=0:
  - data_out <= mem[rd_ptr] on the rd_ok edge, giving 1-cycle latency.
  - data_out holds its value when there is no rd_ok, including while empty.
- Read data, SHOW_AHEAD=1:
  - data_out = mem[rd_ptr] combinationally when !empty, and 0 when empty.
  - rd acts as an acknowledge; the next word appears in the cycle after rd_ok.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
- Errors, registered, each high for exactly one cycle following the offending edge:
  - overflow: wr && full && !rd.
  - underflow: rd && empty.
- Flush (clr):
  - At the edge, pointers and count go to 0, and overflow/underflow go to 0.
  - data_out goes to 0 in SHOW_AHEAD=0 mode; in FWFT mode it reads 0 because the FIFO is empty.
  - clr has priority over wr/rd in the same cycle. Those requests are discarded and raise no error pulses.
- Reset mid-operation: all state returns to reset values immediately (asynchronously). Writes and reads in flight at that edge are lost.
- Parameter checks: elaboration-time assertion that AE_THRESH < AF_THRESH <= DEPTH.

Test Plan (defaults DATA_WIDTH=8, ADDR_WIDTH=4, DEPTH=16, AF=14, AE=2, SHOW_AHEAD=0 unless stated):
- Fill and drain:
  - Write 0x00..0x0F on 16 cycles: full=1 and count=16 after the last edge; almost_full rises the edge count reaches 14.
  - Then 16 reads: data_out = 0x00..0x0F, each 1 cycle after its rd; empty=1 at the end; almost_empty is high at count <= 2.
- Overflow and underflow:
  - At full, wr without rd: overflow pulses 1 cycle, count stays 16, and a later read returns the old data rather than the rejected word.
  - At empty, rd: underflow pulses 1 cycle, and data_out holds its last value.
- Simultaneous at boundaries:
  - At full, wr=rd=1 with data_in=0xAA: count stays 16, no overflow, and 0xAA is read as the 16th word after the draining reads.
  - At empty, wr=rd=1 with 0x55: count becomes 1, underflow pulses, and the next read returns 0x55.
- Wrap-around: push 10, pop 10, then push 16 and pop 16 with an incrementing pattern. The pointers wrap and all data is ordered with no loss.
- FWFT (SHOW_AHEAD=1):
  - Write 0x3C into an empty FIFO: data_out = 0x3C the cycle after the write with no rd.
  - Assert rd: empty=1 and data_out=0 next cycle.
- Flush and reset:
  - With count=9, pulse clr together with wr=1: count=0, empty=1, no words retained.
  - Assert rst asynchronously mid-burst: all outputs take their reset values before the next clk edge.

Source files
------------

// File: rtl/fifo_sync_flags.sv
// ---------------------------------------------------------------------------
// fifo_sync_flags
//   Single-clock FIFO with selectable show-ahead (FWFT) or registered read,
//   programmable almost-full / almost-empty thresholds, occupancy count,
//   overflow / underflow error pulses and a synchronous flush.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   clr           synchronous flush (priority over wr/rd)
//   data_in       write data
//   wr / rd       write / read requests
//   data_out      read data (registered or show-ahead, see SHOW_AHEAD)
//   full, empty   count == DEPTH / count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         occupancy 0..DEPTH
//   overflow      one-cycle pulse after a rejected write
//   underflow     one-cycle pulse after a rejected read
// ---------------------------------------------------------------------------
module fifo_sync_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter bit SHOW_AHEAD = 1'b0,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_MAX = DEPTH[ADDR_WIDTH:0];

    generate
        if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
            $error("fifo_sync_flags: need AE_THRESH < AF_THRESH <= DEPTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  wr_ok, rd_ok;

    // Flags decode straight from the registered count.
    assign full         = (count == CNT_MAX);
    assign empty        = (count == '0);
    assign almost_full  = (int'(count) >= AF_THRESH);
    assign almost_empty = (int'(count) <= AE_THRESH);

    // A read while full frees a slot, so the write is accepted too.
    // A read while empty is rejected even if a write lands this cycle.
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd);

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok && !clr)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            overflow  <= wr && full && !rd;
            underflow <= rd && empty;
        end
    end

    generate
        if (SHOW_AHEAD) begin : g_fwft
            // Head word is visible whenever the FIFO holds data.
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    dout_q <= '0;
                else if (clr)
                    dout_q <= '0;
                else if (rd_ok)
                    dout_q <= mem[rd_ptr];
            end
            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_flags.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_flags
//   Directed bench for fifo_sync_flags. Two instances share the same stimulus:
//   u_dut uses the registered read, u_fwft the show-ahead read. Both accept
//   identically, so their counts and flags track each other.
// ---------------------------------------------------------------------------
module tb_fifo_sync_flags;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic [DW-1:0] data_in;
    logic          wr, rd;

    logic [DW-1:0] data_out, f_data_out;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [AW:0]   count, f_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_sync_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SHOW_AHEAD(1'b0)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .data_in(data_in), .wr(wr), .rd(rd),
        .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    fifo_sync_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SHOW_AHEAD(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .clr(clr), .data_in(data_in), .wr(wr), .rd(rd),
        .data_out(f_data_out), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given requests, then sample 1 time unit after the edge.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        wr = w; rd = r; data_in = d;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wr = 1'b0; rd = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ae", almost_empty, 1);
        chk("rst_af", almost_full, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        chk("rst_fwft_dout", f_data_out, 0);
        rst = 1'b0;

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, DW'(i));
            chk("fill_count", count, i + 1);
            chk("fill_af", almost_full, (i + 1 >= 14) ? 1 : 0);
            chk("fill_ae", almost_empty, (i + 1 <= 2) ? 1 : 0);
        end
        chk("fill_full", full, 1);
        chk("fill_fwft_head", f_data_out, 8'h00);

        // Overflow: write at full, no read
        step(1'b1, 1'b0, 8'hEE);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, 16);
        step(1'b0, 1'b0, 8'h00);
        chk("ovf_drop", overflow, 0);

        // Simultaneous at full: 0xAA goes in, word 0x00 comes out
        step(1'b1, 1'b1, 8'hAA);
        chk("full_rw_count", count, 16);
        chk("full_rw_ovf", overflow, 0);
        chk("full_rw_dout", data_out, 8'h00);

        // Drain: 0x01..0x0F then 0xAA; 0xEE never appears
        for (int j = 0; j < 16; j++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("drain_dout", data_out, (j == 15) ? 8'hAA : j + 1);
            chk("drain_count", count, 15 - j);
            chk("drain_ae", almost_empty, (15 - j <= 2) ? 1 : 0);
        end
        chk("drain_empty", empty, 1);

        // Underflow: read at empty, data_out holds
        step(1'b0, 1'b1, 8'h00);
        chk("unf_pulse", underflow, 1);
        chk("unf_hold", data_out, 8'hAA);
        chk("unf_count", count, 0);
        step(1'b0, 1'b0, 8'h00);
        chk("unf_drop", underflow, 0);

        // Simultaneous at empty: write accepted, read rejected
        step(1'b1, 1'b1, 8'h55);
        chk("empty_rw_count", count, 1);
        chk("empty_rw_unf", underflow, 1);
        chk("empty_rw_dout", data_out, 8'hAA);
        chk("empty_rw_fwft", f_data_out, 8'h55);
        step(1'b0, 1'b1, 8'h00);
        chk("empty_rw_read", data_out, 8'h55);
        chk("empty_rw_cnt0", count, 0);

        // FWFT: word visible the cycle after write, gone after rd
        step(1'b1, 1'b0, 8'h3C);
        chk("fwft_show", f_data_out, 8'h3C);
        chk("fwft_nempty", f_empty, 0);
        step(1'b0, 1'b0, 8'h00);
        chk("fwft_hold", f_data_out, 8'h3C);
        step(1'b0, 1'b1, 8'h00);
        chk("fwft_empty", f_empty, 1);
        chk("fwft_zero", f_data_out, 0);
        chk("fwft_reg_dout", data_out, 8'h3C);

        // Wrap-around: 10 in/out, then 16 in/out
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DW'(8'h10 + i));
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("wrap10", data_out, 8'h10 + i);
        end
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(8'h20 + i));
        chk("wrap16_full", full, 1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("wrap16", data_out, 8'h20 + i);
        end
        chk("wrap_empty", empty, 1);

        // Flush with count=9 and a concurrent write
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, DW'(8'h40 + i));
        chk("pre_clr_count", count, 9);
        clr = 1'b1;
        step(1'b1, 1'b0, 8'h99);
        chk("clr_count", count, 0);
        chk("clr_empty", empty, 1);
        chk("clr_dout", data_out, 0);
        chk("clr_fwft_dout", f_data_out, 0);
        chk("clr_ovf", overflow, 0);
        step(1'b0, 1'b1, 8'h00);
        chk("clr_no_words", underflow, 1);
        chk("clr_no_words_cnt", count, 0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'h60 + i));
        step(1'b1, 1'b1, 8'h65);
        chk("pre_rst_dout", data_out, 8'h60);
        wr = 1'b1; data_in = 8'h66;
        #2 rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_dout", data_out, 0);
        chk("arst_ae", almost_empty, 1);
        chk("arst_fwft_dout", f_data_out, 0);
        @(posedge clk);
        #1 wr = 1'b0; rst = 1'b0;
        chk("arst_held_count", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
